adc_trigger_ctrl: RTL and testbench

ADC_TRIGGER_CTRL -- requirements
Module: adc_trigger_ctrl

---
 rtl/adc_trigger_ctrl.sv | 147 ++++++++++++++
 tb/tb_adc_trigger_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trigger_ctrl.sv
// ADC record controller: captures one channel into a circular buffer around a trigger,
// then streams the record out oldest-first over a valid/ready interface.
module adc_trigger_ctrl #(
    parameter int DATA_W = 14,
    parameter int PRE    = 16,
    parameter int TOTAL  = 64
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              chan_sel,
    input  logic [DATA_W-1:0] threshold,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] a2da_data,
    input  logic [DATA_W-1:0] a2db_data,
    input  logic              ada_or,
    input  logic              adb_or,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [2:0]        state,
    output logic              rec_or,
    output logic [31:0]       trig_ts,
    output logic              rec_done
);
    // state | meaning
    // IDLE  | waiting for arm
    // PRE   | filling the pre-trigger history
    // WAIT  | capturing, looking for a rising crossing or force_trig
    // POST  | capturing the post-trigger samples
    // READ  | streaming the record out oldest-first

    localparam int AW = $clog2(TOTAL);
    localparam int CW = $clog2(TOTAL + 1);
    localparam int RW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_READ = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [TOTAL];
    logic [AW-1:0]     wr_ptr, rd_ptr, rec_start, trig_start;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     rd_left;
    logic [31:0]       ts_cnt;
    logic              chan_q;
    logic [DATA_W-1:0] prev_q, sample;
    logic              sample_or, capturing, trig, xfer, load;

    assign sample     = chan_q ? a2db_data : a2da_data;
    assign sample_or  = chan_q ? adb_or : ada_or;
    assign capturing  = state_q inside {S_PRE, S_WAIT, S_POST};
    // Level alone never triggers: the previous written sample must sit below the threshold.
    assign trig       = (state_q == S_WAIT) &&
                        (force_trig || ((sample >= threshold) && (prev_q < threshold)));
    assign trig_start = wr_ptr - AW'(PRE);
    assign xfer       = out_valid && out_ready;
    assign load       = (state_q == S_READ) && (!out_valid || out_ready) && (rd_left != '0);

    assign busy  = (state_q != S_IDLE);
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm) state_d = S_PRE;
            S_PRE:   if (cnt == '0) state_d = S_WAIT;
            S_WAIT:  if (trig) state_d = (TOTAL - PRE == 1) ? S_READ : S_POST;
            S_POST:  if (cnt == '0) state_d = S_READ;
            S_READ:  if (xfer && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge sys_clk) begin
        if (capturing) mem[wr_ptr] <= sample;
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rec_start <= '0;
            cnt       <= '0;
            rd_left   <= '0;
            ts_cnt    <= '0;
            chan_q    <= 1'b0;
            prev_q    <= '0;
            rec_or    <= 1'b0;
            trig_ts   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            rec_done  <= 1'b0;
        end else begin
            ts_cnt   <= ts_cnt + 32'd1;
            rec_done <= 1'b0;
            if ((state_q == S_IDLE) && arm) begin
                chan_q <= chan_sel;
                rec_or <= 1'b0;
                wr_ptr <= '0;
                cnt    <= CW'(PRE - 1);
            end
            if (capturing) begin
                wr_ptr <= wr_ptr + AW'(1);
                prev_q <= sample;
                rec_or <= rec_or | sample_or;
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
            // The trigger sample itself is the first of the TOTAL-PRE post samples.
            if (trig) begin
                trig_ts   <= ts_cnt;
                rec_start <= trig_start;
                cnt       <= CW'(TOTAL - PRE - 2);
            end
            if ((state_q != S_READ) && (state_d == S_READ)) begin
                rd_ptr  <= trig ? trig_start : rec_start;
                rd_left <= RW'(TOTAL);
            end
            if (state_q == S_READ) begin
                if (load) begin
                    out_data  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                    out_last  <= (rd_left == RW'(1));
                    rd_ptr    <= rd_ptr + AW'(1);
                    rd_left   <= rd_left - RW'(1);
                end else if (xfer) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
                if (xfer && out_last) rec_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adc_trigger_ctrl.sv
// Bench for adc_trigger_ctrl: randomized and directed records checked every cycle
// against a sample-history model, plus literal expectations for the named scenarios.
module tb_adc_trigger_ctrl;
    localparam int DW    = 14;
    localparam int PRE   = 16;
    localparam int TOTAL = 64;
    localparam int ST_IDLE = 0, ST_PRE = 1, ST_WAIT = 2, ST_POST = 3, ST_READ = 4;

    logic          sys_clk, reset, arm, chan_sel, force_trig, ada_or, adb_or, out_ready;
    logic [DW-1:0] threshold, a2da_data, a2db_data, out_data;
    logic          out_valid, out_last, busy, rec_or, rec_done;
    logic [2:0]    state;
    logic [31:0]   trig_ts;

    adc_trigger_ctrl #(.DATA_W(DW), .PRE(PRE), .TOTAL(TOTAL)) dut (
        .sys_clk(sys_clk), .reset(reset), .arm(arm), .chan_sel(chan_sel),
        .threshold(threshold), .force_trig(force_trig),
        .a2da_data(a2da_data), .a2db_data(a2db_data), .ada_or(ada_or), .adb_or(adb_or),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .state(state), .rec_or(rec_or), .trig_ts(trig_ts), .rec_done(rec_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got no event within the cycle budget, expected the event", name);
    endtask

    // ---------------- reference model: sample history and record slice ----------------
    int   m_state = ST_IDLE, m_cnt = 0, trig_idx = 0, rd_idx = 0, rd_cyc = 0;
    logic m_en = 1'b0, m_zero = 1'b0, m_chan = 1'b0, m_or = 1'b0, m_rec_done = 1'b0;
    logic [31:0] m_ts = '0;
    int   hist[$];
    int   exp_q[TOTAL];
    logic seen_valid = 1'b0, stall_prev = 1'b0, prev_last = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic xfer_now, done_now;
    int   s, prv, cnt_now;

    // per-record statistics for the literal checks
    int n_out, n_match, n_done, first_out, last_out, match_val;

    always @(negedge sys_clk) begin
        xfer_now = out_valid && out_ready;
        done_now = 1'b0;
        if (m_en) begin
            chk("state", 32'(state), 32'(m_state));
            chk("busy", 32'(busy), 32'(m_state != ST_IDLE));
            chk("rec_or", 32'(rec_or), 32'(m_or));
            chk("trig_ts", trig_ts, m_ts);
            chk("rec_done", 32'(rec_done), 32'(m_rec_done));
            if (rec_done === 1'b1) n_done++;
            if (m_zero) begin
                chk("rst_out_data", 32'(out_data), 32'd0);
                chk("rst_out_last", 32'(out_last), 32'd0);
            end
            if (m_state == ST_READ) begin
                rd_cyc++;
                if (out_valid) seen_valid = 1'b1;
                if (rd_cyc == 3) chk("first_valid", 32'(seen_valid), 32'd1);
                if (stall_prev) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(prev_data));
                    chk("stall_last", 32'(out_last), 32'(prev_last));
                end
                if (xfer_now) begin
                    if (rd_idx >= TOTAL) begin
                        fail_now("extra_transfer");
                    end else begin
                        chk("out_data", 32'(out_data), 32'(exp_q[rd_idx]));
                        chk("out_last", 32'(out_last), 32'(rd_idx == TOTAL - 1));
                        if (n_out == 0) first_out = int'(out_data);
                        if (out_last) last_out = int'(out_data);
                        if (int'(out_data) == match_val) n_match++;
                        n_out++;
                        rd_idx++;
                        if (rd_idx == TOTAL) done_now = 1'b1;
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end else begin
                chk("out_valid_outside_read", 32'(out_valid), 32'd0);
                stall_prev = 1'b0;
            end
        end

        // advance the model with the inputs that the next rising edge will sample
        if (reset) begin
            m_en = 1'b1; m_zero = 1'b1; m_state = ST_IDLE; m_or = 1'b0;
            m_ts = '0; m_rec_done = 1'b0; m_cnt = 0; stall_prev = 1'b0;
            hist.delete();
        end else if (m_en) begin
            m_zero = 1'b0;
            m_rec_done = 1'b0;
            cnt_now = m_cnt;
            m_cnt++;
            case (m_state)
                ST_IDLE: if (arm) begin
                    m_state = ST_PRE; m_chan = chan_sel; m_or = 1'b0; hist.delete();
                end
                ST_PRE, ST_WAIT, ST_POST: begin
                    s = m_chan ? int'(a2db_data) : int'(a2da_data);
                    hist.push_back(s);
                    m_or = m_or | (m_chan ? adb_or : ada_or);
                    if (m_state == ST_PRE) begin
                        if (hist.size() == PRE) m_state = ST_WAIT;
                    end else if (m_state == ST_WAIT) begin
                        prv = hist[hist.size() - 2];
                        if (force_trig || (s >= int'(threshold) && prv < int'(threshold))) begin
                            trig_idx = hist.size() - 1;
                            m_ts = 32'(cnt_now);
                            m_state = ST_POST;
                        end
                    end
                    if (m_state == ST_POST && hist.size() - trig_idx == TOTAL - PRE) begin
                        for (int i = 0; i < TOTAL; i++) exp_q[i] = hist[trig_idx - PRE + i];
                        m_state = ST_READ; rd_idx = 0; rd_cyc = 0; seen_valid = 1'b0;
                    end
                end
                ST_READ: if (done_now) begin
                    m_state = ST_IDLE; m_rec_done = 1'b1;
                end
                default: m_state = ST_IDLE;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    int            a_mode = 0, b_mode = 0, cyc = 0;
    logic [DW-1:0] a_ramp = '0, a_val = '0, b_val = '0;
    logic          or_rand = 1'b0, rdy_rand = 1'b0, noise_en = 1'b0;

    task automatic drive_data();
        case (a_mode)
            0:       a2da_data = DW'($urandom);
            1:       begin a2da_data = a_ramp; a_ramp = a_ramp + DW'(1); end
            default: a2da_data = a_val;
        endcase
        b_mode_case: case (b_mode)
            0:       a2db_data = DW'($urandom);
            default: a2db_data = b_val;
        endcase
        if (or_rand) begin
            ada_or = ($urandom_range(0, 7) == 0);
            adb_or = ($urandom_range(0, 7) == 0);
        end
        out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (noise_en) begin
            arm        = ($urandom_range(0, 7) == 0);
            force_trig = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic step();
        logic r;
        drive_data();
        r = reset;
        @(posedge sys_clk);
        #1;
        if (r) cyc = 0;
        else   cyc++;
    endtask

    task automatic wait_state(input int code, input int budget, input string name);
        int n = 0;
        while (int'(state) != code && n < budget) begin step(); n++; end
        if (int'(state) != code) fail_now(name);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            step();
            n++;
            if (rec_done === 1'b1) seen = 1'b1;
        end
        arm = 1'b0;
        force_trig = 1'b0;
        if (!seen) fail_now(name);
    endtask

    task automatic clr_stats();
        n_out = 0; n_match = 0; n_done = 0; first_out = -1; last_out = -1; match_val = -1;
    endtask

    task automatic ramp_record(input string name);
        clr_stats();
        chan_sel = 1'b0; a_mode = 1; a_ramp = '0; b_mode = 0; threshold = DW'(100);
        arm = 1'b1; step(); arm = 1'b0;
        wait_done(400, name);
        repeat (3) step();
        chk({name, "_first"}, 32'(first_out), 32'd84);
        chk({name, "_last"}, 32'(last_out), 32'd147);
        chk({name, "_count"}, 32'(n_out), 32'd64);
        chk({name, "_done_pulses"}, 32'(n_done), 32'd1);
    endtask

    int trig_cyc, n_w;

    initial begin
        reset = 1'b1; arm = 1'b0; chan_sel = 1'b0; force_trig = 1'b0;
        ada_or = 1'b0; adb_or = 1'b0; out_ready = 1'b1; threshold = '0;
        a2da_data = '0; a2db_data = '0;
        clr_stats();
        repeat (3) step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_trig_ts", trig_ts, 32'd0);
        chk("rst_rec_or", 32'(rec_or), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // ramp on channel A crossing 100
        ramp_record("ramp");

        // flat channel B, software trigger five cycles into WAIT; stray arm/force ignored
        clr_stats();
        match_val = 'h100;
        chan_sel = 1'b1; b_mode = 2; b_val = DW'('h100); a_mode = 0; threshold = DW'('h200);
        arm = 1'b1; step(); arm = 1'b0; chan_sel = 1'b0;
        force_trig = 1'b1; step(); force_trig = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        wait_state(ST_WAIT, 40, "flat_wait");
        repeat (5) step();
        trig_cyc = cyc;
        force_trig = 1'b1; step(); force_trig = 1'b0;
        chk("flat_post", 32'(state), 32'd3);
        wait_done(300, "flat_done");
        repeat (2) step();
        chk("flat_trig_ts", trig_ts, 32'(trig_cyc));
        chk("flat_match", 32'(n_match), 32'd64);
        chk("flat_count", 32'(n_out), 32'd64);
        chk("flat_rec_or", 32'(rec_or), 32'd0);

        // random records with random back-pressure, OR bits and stray control pulses
        for (int k = 0; k < 4; k++) begin
            clr_stats();
            a_mode = 0; b_mode = 0; or_rand = 1'b1; rdy_rand = 1'b1;
            chan_sel = 1'($urandom_range(0, 1)); threshold = DW'($urandom);
            arm = 1'b1; step(); arm = 1'b0; chan_sel = 1'($urandom_range(0, 1));
            wait_state(ST_WAIT, 40, "rnd_wait");
            n_w = 0;
            while (int'(state) == ST_WAIT && n_w < 60) begin step(); n_w++; end
            if (int'(state) == ST_WAIT) begin force_trig = 1'b1; step(); force_trig = 1'b0; end
            noise_en = 1'b1;
            wait_done(1000, "rnd_done");
            noise_en = 1'b0;
            step();
            chk("rnd_count", 32'(n_out), 32'd64);
            chk("rnd_done_pulses", 32'(n_done), 32'd1);
        end
        or_rand = 1'b0; rdy_rand = 1'b0; ada_or = 1'b0; adb_or = 1'b0;
        repeat (2) step();

        // reset in the middle of POST aborts the record
        clr_stats();
        chan_sel = 1'b0; a_mode = 1; a_ramp = '0; threshold = DW'(100);
        arm = 1'b1; step(); arm = 1'b0;
        wait_state(ST_POST, 200, "abort_post");
        repeat (10) step();
        reset = 1'b1; step();
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_last", 32'(out_last), 32'd0);
        chk("abort_trig_ts", trig_ts, 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        repeat (3) step();
        chk("abort_no_output", 32'(n_out), 32'd0);
        ramp_record("after_abort");

        // channel B selected: A crossing is irrelevant, one B OR pulse is sticky
        clr_stats();
        chan_sel = 1'b1; a_mode = 1; a_ramp = '0; b_mode = 2; b_val = DW'(50); threshold = DW'(100);
        arm = 1'b1; step(); arm = 1'b0;
        wait_state(ST_WAIT, 40, "selb_wait");
        for (int i = 0; i < 150; i++) begin
            if (i == 30) adb_or = 1'b1;
            step();
            adb_or = 1'b0;
        end
        chk("selb_no_trig", 32'(state), 32'd2);
        force_trig = 1'b1; step(); force_trig = 1'b0;
        wait_done(300, "selb_done");
        step();
        chk("selb_rec_or", 32'(rec_or), 32'd1);
        chk("selb_count", 32'(n_out), 32'd64);

        // level already above threshold: needs a fall then a rise
        clr_stats();
        match_val = 50;
        chan_sel = 1'b0; a_mode = 2; a_val = DW'(500); threshold = DW'(100);
        arm = 1'b1; step(); arm = 1'b0;
        wait_state(ST_WAIT, 40, "high_wait");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) arm = 1'b1;
            step();
            arm = 1'b0;
        end
        chk("high_no_trig", 32'(state), 32'd2);
        a_val = DW'(50);
        repeat (3) step();
        a_val = DW'(500);
        trig_cyc = cyc;
        step();
        chk("high_rise_post", 32'(state), 32'd3);
        wait_done(300, "high_done");
        step();
        chk("high_trig_ts", trig_ts, 32'(trig_cyc));
        chk("high_low_samples", 32'(n_match), 32'd3);
        chk("high_last", 32'(last_out), 32'd500);

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
